// File: rtl/dbm_seg_stage.sv
// One stage of the debug-mux observation chain: bypasses, replaces or merges 8 bus segments with local lanes.
// Optional forced apply after a run of busy bus cycles is enabled by defining DBM_SEG_STAGE_APPLY_TIMEOUT_EN.
module dbm_seg_stage #(
    parameter logic [5:0] STAGE_ID      = 6'd1,
    parameter int         NUM_LANES     = 64,
    parameter int         LANE_WIDTH    = 8,
    parameter int         APPLY_TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            csr_wr_en,
    input  logic [63:0]                     csr_wr_data,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] hw_lanes,
    input  logic [8*LANE_WIDTH-1:0]         dbg_in_data,
    input  logic                            dbg_in_valid,
    output logic [8*LANE_WIDTH-1:0]         dbg_out_data,
    output logic                            dbg_out_valid,
    output logic                            cfg_pending,
    output logic                            cfg_applied
);

    localparam int BUS_W = 8 * LANE_WIDTH;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_REPLACE = 2'd1,
        MODE_MERGE   = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    typedef struct packed {
        logic [47:0] sel;
        mode_e       mode;
    } cfg_t;

    if (APPLY_TIMEOUT < 1) begin : g_bad_timeout
        $error("APPLY_TIMEOUT must be at least 1");
    end

    cfg_t shadow_q, shadow_d;
    cfg_t active_q, active_d;
    logic pending_q, pending_d;
    logic applied_q, applied_d;
    logic [BUS_W-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d;

    logic [5:0] wr_id;
    logic wr_accept;
    logic apply;
    logic force_apply;

    logic [5:0]            seg_sel   [8];
    logic [LANE_WIDTH-1:0] lane_data [8];

    assign wr_id     = csr_wr_data[7:2];
    assign wr_accept = csr_wr_en && ((wr_id == STAGE_ID) || (wr_id == 6'h3F));
    assign apply     = pending_q && (!dbg_in_valid || force_apply);

`ifdef DBM_SEG_STAGE_APPLY_TIMEOUT_EN
    localparam int CNT_W = $clog2(APPLY_TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_q, tmo_d;

    // The cycle that would bring the busy count up to APPLY_TIMEOUT applies instead.
    assign force_apply = pending_q && dbg_in_valid && (tmo_q == CNT_W'(APPLY_TIMEOUT - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (apply || !pending_q) begin
            tmo_d = '0;
        end else if (dbg_in_valid) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign force_apply = 1'b0;
`endif

    // An apply and a new write in the same cycle: the old shadow goes live, the new one stays pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        applied_d = apply;
        if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (wr_accept) begin
            shadow_d.sel  = csr_wr_data[63:16];
            shadow_d.mode = mode_e'(csr_wr_data[1:0]);
            pending_d     = 1'b1;
        end
    end

    // Selects beyond the populated lanes match no lane and read as zero.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            seg_sel[k]   = active_q.sel[k*6 +: 6];
            lane_data[k] = '0;
            for (int n = 0; n < NUM_LANES; n++) begin
                if (int'(seg_sel[k]) == n) begin
                    lane_data[k] = hw_lanes[n*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        out_data_d  = '0;
        out_valid_d = 1'b0;
        case (active_q.mode)
            MODE_BYPASS: begin
                out_data_d  = dbg_in_data;
                out_valid_d = dbg_in_valid;
            end
            MODE_REPLACE: begin
                for (int k = 0; k < 8; k++) begin
                    out_data_d[k*LANE_WIDTH +: LANE_WIDTH] = lane_data[k];
                end
                out_valid_d = 1'b1;
            end
            MODE_MERGE: begin
                for (int k = 0; k < 8; k++) begin
                    if (seg_sel[k] != 6'd0) begin
                        out_data_d[k*LANE_WIDTH +: LANE_WIDTH] = lane_data[k];
                    end else if (dbg_in_valid) begin
                        out_data_d[k*LANE_WIDTH +: LANE_WIDTH] = dbg_in_data[k*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
                out_valid_d = 1'b1;
            end
            default: begin
                out_data_d  = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            applied_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            applied_q   <= applied_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dbg_out_data  = out_data_q;
    assign dbg_out_valid = out_valid_q;
    assign cfg_pending   = pending_q;
    assign cfg_applied   = applied_q;

endmodule

// File: tb/tb_dbm_seg_stage.sv
// Directed bench for dbm_seg_stage: a vector table plus hand-written sequences for
// write/apply collisions, reset while pending and the apply timeout.
module tb_dbm_seg_stage;

    localparam int NUM_LANES  = 64;
    localparam int LANE_WIDTH = 8;

    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D2 = 64'hCAFEBABEDEADBEEF;
    localparam logic [63:0] D3 = 64'h0123456789ABCDEF;
    localparam logic [63:0] DM = 64'h112233443C667788;
    localparam logic [63:0] M1 = 64'hA0A0A0A0A0A0A0A5;
    localparam logic [63:0] MV = 64'h88A533A93C9FA2A1;
    localparam logic [63:0] MB = 64'h88A500A9009FA2A1;

    localparam logic [47:0] SEL_S0_5 = {42'd0, 6'd5};
    localparam logic [47:0] SEL_MRG  = {6'd40, 6'd5, 6'd0, 6'd9, 6'd0, 6'd63, 6'd2, 6'd1};

    logic                            clk;
    logic                            reset;
    logic                            csr_wr_en;
    logic [63:0]                     csr_wr_data;
    logic [NUM_LANES*LANE_WIDTH-1:0] hw_lanes;
    logic [8*LANE_WIDTH-1:0]         dbg_in_data;
    logic                            dbg_in_valid;
    logic [8*LANE_WIDTH-1:0]         dbg_out_data;
    logic                            dbg_out_valid;
    logic                            cfg_pending;
    logic                            cfg_applied;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        string       name;
        logic        wr_en;
        logic [63:0] wr_data;
        logic        in_valid;
        logic [63:0] in_data;
        logic [63:0] exp_data;
        logic        exp_valid;
        logic        exp_pending;
        logic        exp_applied;
    } vec_t;

    vec_t vecs[$];

    dbm_seg_stage #(
        .STAGE_ID     (6'd1),
        .NUM_LANES    (NUM_LANES),
        .LANE_WIDTH   (LANE_WIDTH),
        .APPLY_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .csr_wr_en    (csr_wr_en),
        .csr_wr_data  (csr_wr_data),
        .hw_lanes     (hw_lanes),
        .dbg_in_data  (dbg_in_data),
        .dbg_in_valid (dbg_in_valid),
        .dbg_out_data (dbg_out_data),
        .dbg_out_valid(dbg_out_valid),
        .cfg_pending  (cfg_pending),
        .cfg_applied  (cfg_applied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] csr(input logic [5:0] id, input logic [1:0] mode, input logic [47:0] sels);
        return {sels, 8'h00, id, mode};
    endfunction

    task automatic addVec(input string name, input logic wr_en, input logic [63:0] wr_data,
                          input logic in_valid, input logic [63:0] in_data, input logic [63:0] exp_data,
                          input logic exp_valid, input logic exp_pending, input logic exp_applied);
        vec_t v;
        v.name = name; v.wr_en = wr_en; v.wr_data = wr_data; v.in_valid = in_valid; v.in_data = in_data;
        v.exp_data = exp_data; v.exp_valid = exp_valid; v.exp_pending = exp_pending; v.exp_applied = exp_applied;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, take the edge, and settle 1 time unit past it.
    task automatic applyStimulus(input logic wr_en, input logic [63:0] wr_data,
                                 input logic in_valid, input logic [63:0] in_data);
        csr_wr_en    = wr_en;
        csr_wr_data  = wr_data;
        dbg_in_valid = in_valid;
        dbg_in_data  = in_data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] exp_data, input logic exp_valid,
                               input logic exp_pending, input logic exp_applied);
        bit bad = 0;
        vectors_applied++;
        if (dbg_out_data !== exp_data) begin
            $display("[TB] FAIL %s data: got %h want %h", name, dbg_out_data, exp_data);
            bad = 1;
        end
        if (dbg_out_valid !== exp_valid) begin
            $display("[TB] FAIL %s valid: got %b want %b", name, dbg_out_valid, exp_valid);
            bad = 1;
        end
        if (cfg_pending !== exp_pending) begin
            $display("[TB] FAIL %s pending: got %b want %b", name, cfg_pending, exp_pending);
            bad = 1;
        end
        if (cfg_applied !== exp_applied) begin
            $display("[TB] FAIL %s applied: got %b want %b", name, cfg_applied, exp_applied);
            bad = 1;
        end
        if (bad) miscompares++;
    endtask

    task automatic checkFlags(input string name, input logic exp_pending, input logic exp_applied);
        vectors_applied++;
        if (cfg_pending !== exp_pending || cfg_applied !== exp_applied) begin
            $display("[TB] FAIL %s: got pending=%b applied=%b want pending=%b applied=%b",
                     name, cfg_pending, cfg_applied, exp_pending, exp_applied);
            miscompares++;
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        vectors_applied++;
        if (got != want) begin
            $display("[TB] FAIL %s: got %0d cycles want %0d", name, got, want);
            miscompares++;
        end
    endtask

    initial begin
        int hi_cnt;

        for (int n = 0; n < NUM_LANES; n++) begin
            hw_lanes[n*LANE_WIDTH +: LANE_WIDTH] = 8'hA0 ^ 8'(n);
        end

        //     name              wr  wr_data                  iv  in_data  exp_data  ev  pend app
        addVec("bypass_start",   0, 64'd0,                    1,  D1,      D1,       1,  0,   0);
        addVec("wr_id1_mode1",   1, csr(6'd1, 2'd1, SEL_S0_5), 0,  D2,      D2,       0,  1,   0);
        addVec("apply_bubble",   0, 64'd0,                    0,  D3,      D3,       0,  0,   1);
        addVec("replace_out",    0, 64'd0,                    1,  D1,      M1,       1,  0,   0);
        addVec("wr_id2_ignored", 1, csr(6'd2, 2'd0, 48'd0),   1,  D1,      M1,       1,  0,   0);
        addVec("ignored_stays",  0, 64'd0,                    0,  D1,      M1,       1,  0,   0);
        addVec("wr_bcast_merge", 1, csr(6'h3F, 2'd2, SEL_MRG), 1, D1,      M1,       1,  1,   0);
        addVec("pend_busy",      0, 64'd0,                    1,  D1,      M1,       1,  1,   0);
        addVec("apply_merge",    0, 64'd0,                    0,  D1,      M1,       1,  0,   1);
        addVec("merge_valid",    0, 64'd0,                    1,  DM,      MV,       1,  0,   0);
        addVec("merge_bubble",   0, 64'd0,                    0,  DM,      MB,       1,  0,   0);
        addVec("wr_off",         1, csr(6'd1, 2'd3, 48'd0),   0,  DM,      MB,       1,  1,   0);
        addVec("apply_off",      0, 64'd0,                    0,  DM,      MB,       1,  0,   1);
        addVec("off_out",        0, 64'd0,                    1,  D1,      64'd0,    0,  0,   0);
        addVec("wr_bypass",      1, csr(6'd1, 2'd0, 48'd0),   1,  D1,      64'd0,    0,  1,   0);
        addVec("apply_bypass",   0, 64'd0,                    0,  D1,      64'd0,    0,  0,   1);
        addVec("bypass_again",   0, 64'd0,                    1,  D2,      D2,       1,  0,   0);
        addVec("wr_id2_bypass",  1, csr(6'd2, 2'd1, SEL_S0_5), 1, D3,      D3,       1,  0,   0);
        addVec("bypass_track",   0, 64'd0,                    0,  D1,      D1,       0,  0,   0);

        reset        = 1'b1;
        csr_wr_en    = 1'b0;
        csr_wr_data  = '0;
        dbg_in_valid = 1'b1;
        dbg_in_data  = D1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 64'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr_en, vecs[i].wr_data, vecs[i].in_valid, vecs[i].in_data);
            checkOutput(vecs[i].name, vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_pending, vecs[i].exp_applied);
        end

        // Write landing on an apply edge: old shadow goes live, new write waits for the next bubble.
        applyStimulus(1, csr(6'd1, 2'd1, SEL_S0_5), 1, D1);
        checkOutput("coll_pend", D1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, csr(6'd1, 2'd3, 48'd0), 0, D2);
        checkOutput("coll_apply", D2, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 64'd0, 1, D1);
        checkOutput("coll_old_live", M1, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 64'd0, 0, D1);
        checkOutput("coll_second_apply", M1, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 64'd0, 1, D1);
        checkOutput("coll_new_live", 64'd0, 1'b0, 1'b0, 1'b0);

        // Reset while a merge config is pending under an active replace config.
        applyStimulus(1, csr(6'd1, 2'd1, SEL_S0_5), 0, D1);
        applyStimulus(0, 64'd0, 0, D1);
        applyStimulus(0, 64'd0, 1, D1);
        checkOutput("pre_reset_replace", M1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, csr(6'd1, 2'd2, SEL_MRG), 1, D1);
        checkFlags("pre_reset_pending", 1'b1, 1'b0);
        #2;
        reset     = 1'b1;
        csr_wr_en = 1'b0;
        #1;
        checkOutput("reset_immediate", 64'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 64'd0, 1, D2);
        checkOutput("post_reset_bypass", D2, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 64'd0, 0, D3);
        checkOutput("post_reset_no_apply", D3, 1'b0, 1'b0, 1'b0);

        // Pending config with the bus held busy.
        applyStimulus(1, csr(6'd1, 2'd1, SEL_S0_5), 1, D1);
        checkOutput("tmo_pend", D1, 1'b1, 1'b1, 1'b0);
        hi_cnt = 0;
`ifdef DBM_SEG_STAGE_APPLY_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 64'd0, 1, D1);
            if (cfg_pending) hi_cnt++;
        end
        checkCount("tmo_hold", hi_cnt, 15);
        applyStimulus(0, 64'd0, 1, D1);
        checkFlags("tmo_forced_apply", 1'b0, 1'b1);
`else
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 64'd0, 1, D1);
            if (cfg_pending) hi_cnt++;
        end
        checkCount("tmo_hold", hi_cnt, 40);
        applyStimulus(0, 64'd0, 0, D1);
        checkFlags("tmo_bubble_apply", 1'b0, 1'b1);
`endif
        applyStimulus(0, 64'd0, 1, D1);
        checkOutput("tmo_replace_live", M1, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
